scmp_bus_ctl: RTL and testbench
===============================

SCMP_BUS_CTL -- requirements
Module: scmp_bus_ctl

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
  clk  in  1  system clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  cpu_req  in  1  microcode bus-cycle request, held until cpu_ack
  cpu_wr  in  1  1=write, 0=read
  cpu_flags  in  4  {H,D,I,R} status flags for the cycle
  cpu_addr  in  16  cycle address
  cpu_wdata  in  8  write data
  cpu_rdata  out  8  read data, valid with cpu_ack
  cpu_ack  out  1  one-cycle completion pulse
  cpu_stall  out  1  microcode hold: cpu_req & ~cpu_ack
  bus_breq_n  out  1  bus request, active-low
  bus_enin  in  1  bus grant / daisy-chain enable in
  bus_enout  out  1  daisy-chain enable out
  bus_ads_n / bus_rd_n / bus_wr_n  out  1 each  address, read, write strobes, active-low
  bus_hold  in  1  wait-state extend
  bus_addr  out  16  external address
  bus_flags  out  4  {H,D,I,R} driven with address
  bus_d_o  out  8  write data
  bus_d_oe  out  1  data output enable
  bus_d_i  in  8  read data
  dma_req, dma_wr, dma_addr[15:0], dma_wdata[7:0]  in; dma_rdata[7:0], dma_ack  out -- present only with SCMP_DMA_PORT_EN, same meaning as cpu_* counterparts.

Function
REQ-002 FSM states SHALL be IDLE, REQ, ADDR, DATA, DONE.
REQ-003 IDLE: if any request pending, SHALL latch winner's wr/addr/wdata/flags (flags zero for DMA) and go to REQ; otherwise stay.
REQ-004 REQ: bus_breq_n=0; SHALL go to ADDR on first cycle bus_enin=1, else wait indefinitely.
REQ-005 ADDR: exactly one cycle, bus_ads_n=0, bus_breq_n=0, bus_addr/bus_flags driven.
REQ-006 DATA: bus_rd_n=0 (read) or bus_wr_n=0 with bus_d_oe=1 (write); minimum 2 cycles, then SHALL remain while bus_hold=1.
REQ-007 Read data SHALL be captured from bus_d_i on the last DATA cycle.
REQ-008 DONE: one cycle, all strobes high, bus_d_oe=0, bus_addr/flags still held, bus_breq_n=1, ack pulsed to granted requester only; next state IDLE.
REQ-009 Latency with bus_enin=1 and bus_hold=0: req sampled in IDLE at cycle N -> ack high in cycle N+5; each hold cycle adds one.
REQ-010 bus_enin falling after ADDR SHALL be ignored; cycle completes.
REQ-011 Requester dropping req mid-cycle: cycle SHALL complete; ack still pulsed.
REQ-012 bus_enout SHALL equal bus_enin & (state==IDLE) & no request pending.
REQ-013 Back-to-back: req held after ack SHALL start a new cycle from IDLE (one idle cycle between DONE and REQ).
REQ-014 Outside ADDR/DATA/DONE, bus_addr, bus_flags, bus_d_o SHALL be zero.

Reset
REQ-015 rst_n low SHALL force IDLE immediately: bus_breq_n, bus_ads_n, bus_rd_n, bus_wr_n = 1; bus_d_oe, acks, rdata, bus_addr, bus_flags = 0; last-grant = DMA.
REQ-016 Reset mid-cycle SHALL abort without ack; no pending state survives.

Configuration
REQ-017 Macro SCMP_DMA_PORT_EN: defined -> DMA port present; undefined -> DMA ports absent, CPU sole requester, no arbitration logic.
REQ-018 With SCMP_DMA_PORT_EN, simultaneous requests in IDLE SHALL be granted to the requester not granted last (alternating); a lone requester always wins.

Verification
REQ-019 CPU read, enin=1, hold=0, bus_d_i=0x5A, addr 0x1234 -> ads_n low cycle N+2, rd_n low N+3..N+4, cpu_ack N+5, cpu_rdata=0x5A.
REQ-020 CPU write 0xA5 to 0x0FFF, hold=1 for 3 cycles after DATA min -> wr_n low 5 cycles, d_oe=1 with d_o=0xA5 throughout, ack at N+8.
REQ-021 enin=0 for 4 cycles in REQ -> breq_n low, ads_n stays high 4 cycles, enout=0; cycle completes after enin=1.
REQ-022 rst_n low during DATA -> all strobes high, breq_n=1 same cycle, no ack.
REQ-023 SCMP_DMA_PORT_EN: cpu_req and dma_req held together -> grants alternate CPU,DMA,CPU,DMA; cpu_stall high until each cpu_ack.
REQ-024 Idle, no requests, enin=1 -> enout=1; cpu_req asserted -> enout=0 same cycle.

Source files
------------

// File: rtl/scmp_bus_ctl.sv
// scmp_bus_ctl: SC/MP-style external bus-cycle controller.
// Runs one bus cycle at a time (request, address strobe, read/write data
// phase with wait-state extension, completion) on behalf of the microcode
// requester. Defining SCMP_DMA_PORT_EN adds a second (DMA) requester that
// alternates with the CPU when both ask in the same cycle.
module scmp_bus_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [3:0]  cpu_flags,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  output logic        bus_breq_n,
  input  logic        bus_enin,
  output logic        bus_enout,
  output logic        bus_ads_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  input  logic        bus_hold,
  output logic [15:0] bus_addr,
  output logic [3:0]  bus_flags,
  output logic [7:0]  bus_d_o,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_i
`ifdef SCMP_DMA_PORT_EN
  ,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t      state;

  // Cycle parameters captured when the cycle is granted.
  logic        cyc_wr;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic [3:0]  cyc_flags;

  // Set after the first DATA cycle; the data phase is never shorter than two.
  logic        data_min_done;
  logic [7:0]  rdata_q;
  logic        any_req;

`ifdef SCMP_DMA_PORT_EN
  // last_dma remembers the previous winner; owner_dma routes the ack.
  logic        last_dma;
  logic        owner_dma;
  logic        pick_dma;

  assign any_req   = cpu_req | dma_req;
  assign pick_dma  = dma_req & (~cpu_req | ~last_dma);
  assign dma_rdata = rdata_q;
`else
  assign any_req   = cpu_req;
`endif

  assign cpu_rdata = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign bus_enout = bus_enin & (state == IDLE) & ~any_req;

  // Bus-cycle sequencer; every bus strobe and ack is a flop set on the
  // transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cyc_wr        <= 1'b0;
      cyc_addr      <= 16'h0000;
      cyc_wdata     <= 8'h00;
      cyc_flags     <= 4'h0;
      data_min_done <= 1'b0;
      rdata_q       <= 8'h00;
      cpu_ack       <= 1'b0;
      bus_breq_n    <= 1'b1;
      bus_ads_n     <= 1'b1;
      bus_rd_n      <= 1'b1;
      bus_wr_n      <= 1'b1;
      bus_d_oe      <= 1'b0;
      bus_addr      <= 16'h0000;
      bus_flags     <= 4'h0;
      bus_d_o       <= 8'h00;
`ifdef SCMP_DMA_PORT_EN
      dma_ack       <= 1'b0;
      last_dma      <= 1'b1;
      owner_dma     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= REQ;
            bus_breq_n <= 1'b0;
`ifdef SCMP_DMA_PORT_EN
            owner_dma <= pick_dma;
            last_dma  <= pick_dma;
            if (pick_dma) begin
              cyc_wr    <= dma_wr;
              cyc_addr  <= dma_addr;
              cyc_wdata <= dma_wdata;
              cyc_flags <= 4'h0;
            end else begin
              cyc_wr    <= cpu_wr;
              cyc_addr  <= cpu_addr;
              cyc_wdata <= cpu_wdata;
              cyc_flags <= cpu_flags;
            end
`else
            cyc_wr    <= cpu_wr;
            cyc_addr  <= cpu_addr;
            cyc_wdata <= cpu_wdata;
            cyc_flags <= cpu_flags;
`endif
          end
        end

        REQ: begin
          if (bus_enin) begin
            state     <= ADDR;
            bus_ads_n <= 1'b0;
            bus_addr  <= cyc_addr;
            bus_flags <= cyc_flags;
            bus_d_o   <= cyc_wr ? cyc_wdata : 8'h00;
          end
        end

        ADDR: begin
          state         <= DATA;
          bus_ads_n     <= 1'b1;
          data_min_done <= 1'b0;
          if (cyc_wr) begin
            bus_wr_n <= 1'b0;
            bus_d_oe <= 1'b1;
          end else begin
            bus_rd_n <= 1'b0;
          end
        end

        DATA: begin
          if (!data_min_done) begin
            data_min_done <= 1'b1;
          end else if (!bus_hold) begin
            state      <= DONE;
            bus_rd_n   <= 1'b1;
            bus_wr_n   <= 1'b1;
            bus_d_oe   <= 1'b0;
            bus_breq_n <= 1'b1;
            if (!cyc_wr) begin
              rdata_q <= bus_d_i;
            end
`ifdef SCMP_DMA_PORT_EN
            if (owner_dma) begin
              dma_ack <= 1'b1;
            end else begin
              cpu_ack <= 1'b1;
            end
`else
            cpu_ack <= 1'b1;
`endif
          end
        end

        DONE: begin
          state     <= IDLE;
          cpu_ack   <= 1'b0;
          bus_addr  <= 16'h0000;
          bus_flags <= 4'h0;
          bus_d_o   <= 8'h00;
`ifdef SCMP_DMA_PORT_EN
          dma_ack   <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// tb_scmp_bus_ctl: directed, table-driven bench for scmp_bus_ctl.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge. Multi-cycle corner cases are hand-written sequences.
module tb_scmp_bus_ctl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_wr;
  logic [3:0]  cpu_flags;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_stall;
  logic        bus_breq_n;
  logic        bus_enin;
  logic        bus_enout;
  logic        bus_ads_n;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_hold;
  logic [15:0] bus_addr;
  logic [3:0]  bus_flags;
  logic [7:0]  bus_d_o;
  logic        bus_d_oe;
  logic [7:0]  bus_d_i;
`ifdef SCMP_DMA_PORT_EN
  logic        dma_req;
  logic        dma_wr;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
`endif

  int checks;
  int failures;
  int lat;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [3:0]  flags;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        enin;
    logic        hold;
    logic [7:0]  din;
    logic        ack;
    logic [7:0]  rdata;
    logic        breq_n;
    logic        ads_n;
    logic        rd_n;
    logic        wr_n;
    logic        d_oe;
    logic [15:0] baddr;
    logic [3:0]  bflags;
    logic [7:0]  d_o;
    logic        enout;
    logic        stall;
  } vec_t;

  vec_t vecs[$];

  scmp_bus_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_flags  (cpu_flags),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_stall  (cpu_stall),
    .bus_breq_n (bus_breq_n),
    .bus_enin   (bus_enin),
    .bus_enout  (bus_enout),
    .bus_ads_n  (bus_ads_n),
    .bus_rd_n   (bus_rd_n),
    .bus_wr_n   (bus_wr_n),
    .bus_hold   (bus_hold),
    .bus_addr   (bus_addr),
    .bus_flags  (bus_flags),
    .bus_d_o    (bus_d_o),
    .bus_d_oe   (bus_d_oe),
    .bus_d_i    (bus_d_i)
`ifdef SCMP_DMA_PORT_EN
    ,
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .dma_ack    (dma_ack)
`endif
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit in case a sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic req, input logic wr, input logic [3:0] flags,
    input logic [15:0] addr, input logic [7:0] wdata, input logic enin,
    input logic hold, input logic [7:0] din,
    input logic ack, input logic [7:0] rdata, input logic breq_n,
    input logic ads_n, input logic rd_n, input logic wr_n, input logic d_oe,
    input logic [15:0] baddr, input logic [3:0] bflags, input logic [7:0] d_o,
    input logic enout, input logic stall);
    vec_t v;
    v.req = req;     v.wr = wr;       v.flags = flags;   v.addr = addr;
    v.wdata = wdata; v.enin = enin;   v.hold = hold;     v.din = din;
    v.ack = ack;     v.rdata = rdata; v.breq_n = breq_n; v.ads_n = ads_n;
    v.rd_n = rd_n;   v.wr_n = wr_n;   v.d_oe = d_oe;     v.baddr = baddr;
    v.bflags = bflags; v.d_o = d_o;   v.enout = enout;   v.stall = stall;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    cpu_req   = v.req;
    cpu_wr    = v.wr;
    cpu_flags = v.flags;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    bus_enin  = v.enin;
    bus_hold  = v.hold;
    bus_d_i   = v.din;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d_ack", i),    {31'd0, cpu_ack},    {31'd0, v.ack});
    checkOutput($sformatf("v%0d_rdata", i),  {24'd0, cpu_rdata},  {24'd0, v.rdata});
    checkOutput($sformatf("v%0d_breq_n", i), {31'd0, bus_breq_n}, {31'd0, v.breq_n});
    checkOutput($sformatf("v%0d_ads_n", i),  {31'd0, bus_ads_n},  {31'd0, v.ads_n});
    checkOutput($sformatf("v%0d_rd_n", i),   {31'd0, bus_rd_n},   {31'd0, v.rd_n});
    checkOutput($sformatf("v%0d_wr_n", i),   {31'd0, bus_wr_n},   {31'd0, v.wr_n});
    checkOutput($sformatf("v%0d_d_oe", i),   {31'd0, bus_d_oe},   {31'd0, v.d_oe});
    checkOutput($sformatf("v%0d_baddr", i),  {16'd0, bus_addr},   {16'd0, v.baddr});
    checkOutput($sformatf("v%0d_bflags", i), {28'd0, bus_flags},  {28'd0, v.bflags});
    checkOutput($sformatf("v%0d_d_o", i),    {24'd0, bus_d_o},    {24'd0, v.d_o});
    checkOutput($sformatf("v%0d_enout", i),  {31'd0, bus_enout},  {31'd0, v.enout});
    checkOutput($sformatf("v%0d_stall", i),  {31'd0, cpu_stall},  {31'd0, v.stall});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the current one until cpu_ack is seen; -1 on timeout.
  // Returns at the falling edge of the ack cycle.
  task automatic waitCpuAck(input int max_cycles, output int n);
    n = 0;
    @(negedge clk);
    while (cpu_ack !== 1'b1 && n < max_cycles) begin
      nextCycle();
      n++;
      @(negedge clk);
    end
    if (cpu_ack !== 1'b1) n = -1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_flags = 4'h0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    bus_enin  = 1'b1;
    bus_hold  = 1'b0;
    bus_d_i   = 8'h00;
`ifdef SCMP_DMA_PORT_EN
    dma_req   = 1'b0;
    dma_wr    = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
`endif

    // Idle row, CPU read of 0x1234 (data valid only on last DATA cycle),
    // then CPU write of 0xA5 to 0x0FFF with three hold cycles.
    vecs.push_back(mk(0,0,4'h0,16'h0000,8'h00,1,0,8'h00, 0,8'h00,1,1,1,1,0,16'h0000,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,0,4'hA,16'h1234,8'h00,1,0,8'h00, 0,8'h00,1,1,1,1,0,16'h0000,4'h0,8'h00,0,1));
    vecs.push_back(mk(1,0,4'hF,16'hBEEF,8'h00,1,0,8'h00, 0,8'h00,0,1,1,1,0,16'h0000,4'h0,8'h00,0,1));
    vecs.push_back(mk(1,0,4'hF,16'hBEEF,8'h00,1,0,8'h00, 0,8'h00,0,0,1,1,0,16'h1234,4'hA,8'h00,0,1));
    vecs.push_back(mk(1,0,4'hF,16'hBEEF,8'h00,1,0,8'h11, 0,8'h00,0,1,0,1,0,16'h1234,4'hA,8'h00,0,1));
    vecs.push_back(mk(1,0,4'hF,16'hBEEF,8'h00,1,0,8'h5A, 0,8'h00,0,1,0,1,0,16'h1234,4'hA,8'h00,0,1));
    vecs.push_back(mk(1,0,4'hF,16'hBEEF,8'h00,1,0,8'h00, 1,8'h5A,1,1,1,1,0,16'h1234,4'hA,8'h00,0,0));
    vecs.push_back(mk(0,0,4'h0,16'h0000,8'h00,1,0,8'h00, 0,8'h5A,1,1,1,1,0,16'h0000,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,1,4'h5,16'h0FFF,8'hA5,1,0,8'h5A, 0,8'h5A,1,1,1,1,0,16'h0000,4'h0,8'h00,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,0,8'h5A, 0,8'h5A,0,1,1,1,0,16'h0000,4'h0,8'h00,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,0,8'h5A, 0,8'h5A,0,0,1,1,0,16'h0FFF,4'h5,8'hA5,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,0,8'h5A, 0,8'h5A,0,1,1,0,1,16'h0FFF,4'h5,8'hA5,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,1,8'h5A, 0,8'h5A,0,1,1,0,1,16'h0FFF,4'h5,8'hA5,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,1,8'h5A, 0,8'h5A,0,1,1,0,1,16'h0FFF,4'h5,8'hA5,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,1,8'h5A, 0,8'h5A,0,1,1,0,1,16'h0FFF,4'h5,8'hA5,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,0,8'h5A, 0,8'h5A,0,1,1,0,1,16'h0FFF,4'h5,8'hA5,0,1));
    vecs.push_back(mk(1,1,4'h0,16'h0000,8'h00,1,0,8'h5A, 1,8'h5A,1,1,1,1,0,16'h0FFF,4'h5,8'hA5,0,0));
    vecs.push_back(mk(0,0,4'h0,16'h0000,8'h00,1,0,8'h5A, 0,8'h5A,1,1,1,1,0,16'h0000,4'h0,8'h00,1,0));

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_breq_n", {31'd0, bus_breq_n}, 32'd1);
    checkOutput("rst_ads_n",  {31'd0, bus_ads_n},  32'd1);
    checkOutput("rst_rd_n",   {31'd0, bus_rd_n},   32'd1);
    checkOutput("rst_wr_n",   {31'd0, bus_wr_n},   32'd1);
    checkOutput("rst_d_oe",   {31'd0, bus_d_oe},   32'd0);
    checkOutput("rst_ack",    {31'd0, cpu_ack},    32'd0);
    checkOutput("rst_rdata",  {24'd0, cpu_rdata},  32'd0);
    checkOutput("rst_addr",   {16'd0, bus_addr},   32'd0);
    checkOutput("rst_flags",  {28'd0, bus_flags},  32'd0);
    nextCycle();
    rst_n = 1'b1;

    // Table-driven cycle-by-cycle traces.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      nextCycle();
    end

    // enout follows a new request combinationally, then enin held low in REQ.
    cpu_req = 1'b0;
    bus_enin = 1'b1;
    #1;
    checkOutput("enout_idle", {31'd0, bus_enout}, 32'd1);
    cpu_req   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h4321;
    cpu_flags = 4'h3;
    #1;
    checkOutput("enout_req_same_cycle", {31'd0, bus_enout}, 32'd0);
    bus_enin = 1'b0;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("req_wait%0d_breq_n", i), {31'd0, bus_breq_n}, 32'd0);
      checkOutput($sformatf("req_wait%0d_ads_n", i),  {31'd0, bus_ads_n},  32'd1);
      checkOutput($sformatf("req_wait%0d_enout", i),  {31'd0, bus_enout},  32'd0);
      nextCycle();
    end
    bus_enin = 1'b1;
    @(negedge clk);
    checkOutput("req_grant_ads_n", {31'd0, bus_ads_n}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("late_addr_ads_n", {31'd0, bus_ads_n}, 32'd0);
    checkOutput("late_addr_addr",  {16'd0, bus_addr},  32'h4321);
    nextCycle();
    // Grant and request both drop during DATA; the cycle must still finish.
    bus_enin = 1'b0;
    cpu_req  = 1'b0;
    bus_d_i  = 8'hC3;
    waitCpuAck(10, lat);
    checkOutput("drop_lat", lat, 32'd2);
    checkOutput("drop_rdata", {24'd0, cpu_rdata}, 32'hC3);
    nextCycle();
    bus_enin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("drop_idle%0d_ack", i),    {31'd0, cpu_ack},    32'd0);
      checkOutput($sformatf("drop_idle%0d_breq_n", i), {31'd0, bus_breq_n}, 32'd1);
      nextCycle();
    end

    // Back-to-back reads with cpu_req held throughout.
    cpu_req   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h00AA;
    cpu_flags = 4'h0;
    bus_d_i   = 8'h77;
    waitCpuAck(20, lat);
    checkOutput("b2b_lat1", lat, 32'd5);
    checkOutput("b2b_rdata1", {24'd0, cpu_rdata}, 32'h77);
    nextCycle();
    bus_d_i = 8'h88;
    @(negedge clk);
    checkOutput("b2b_gap_breq_n", {31'd0, bus_breq_n}, 32'd1);
    checkOutput("b2b_gap_ack",    {31'd0, cpu_ack},    32'd0);
    nextCycle();
    waitCpuAck(20, lat);
    checkOutput("b2b_lat2", lat, 32'd4);
    checkOutput("b2b_rdata2", {24'd0, cpu_rdata}, 32'h88);
    cpu_req = 1'b0;
    nextCycle();

    // Reset asserted in the middle of a write data phase.
    cpu_req   = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = 16'h2000;
    cpu_wdata = 8'h3C;
    cpu_flags = 4'hF;
    nextCycle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_pre_wr_n", {31'd0, bus_wr_n}, 32'd0);
    checkOutput("rst_pre_d_oe", {31'd0, bus_d_oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_breq_n", {31'd0, bus_breq_n}, 32'd1);
    checkOutput("mid_rst_ads_n",  {31'd0, bus_ads_n},  32'd1);
    checkOutput("mid_rst_rd_n",   {31'd0, bus_rd_n},   32'd1);
    checkOutput("mid_rst_wr_n",   {31'd0, bus_wr_n},   32'd1);
    checkOutput("mid_rst_d_oe",   {31'd0, bus_d_oe},   32'd0);
    checkOutput("mid_rst_ack",    {31'd0, cpu_ack},    32'd0);
    checkOutput("mid_rst_addr",   {16'd0, bus_addr},   32'd0);
    checkOutput("mid_rst_d_o",    {24'd0, bus_d_o},    32'd0);
    checkOutput("mid_rst_rdata",  {24'd0, cpu_rdata},  32'd0);
    cpu_req = 1'b0;
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst%0d_ack", i),    {31'd0, cpu_ack},    32'd0);
      checkOutput($sformatf("post_rst%0d_breq_n", i), {31'd0, bus_breq_n}, 32'd1);
      nextCycle();
    end

`ifdef SCMP_DMA_PORT_EN
    // Simultaneous CPU and DMA requests alternate, starting with the CPU.
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    cpu_req   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h1111;
    cpu_flags = 4'h9;
    dma_req   = 1'b1;
    dma_wr    = 1'b0;
    dma_addr  = 16'h2222;
    for (int g = 0; g < 4; g++) begin
      int n;
      logic exp_dma;
      exp_dma = (g % 2) == 1;
      n = 0;
      @(negedge clk);
      while (!(cpu_ack === 1'b1 || dma_ack === 1'b1) && n < 20) begin
        checkOutput($sformatf("dma_g%0d_stall", g), {31'd0, cpu_stall}, 32'd1);
        nextCycle();
        n++;
        @(negedge clk);
      end
      if (n >= 20) begin
        checkOutput($sformatf("dma_g%0d_timeout", g), 32'd1, 32'd0);
        break;
      end
      checkOutput($sformatf("dma_g%0d_owner", g), {31'd0, dma_ack}, {31'd0, exp_dma});
      checkOutput($sformatf("dma_g%0d_cpu_ack", g), {31'd0, cpu_ack}, {31'd0, ~exp_dma});
      checkOutput($sformatf("dma_g%0d_addr", g), {16'd0, bus_addr}, exp_dma ? 32'h2222 : 32'h1111);
      checkOutput($sformatf("dma_g%0d_flags", g), {28'd0, bus_flags}, exp_dma ? 32'h0 : 32'h9);
      nextCycle();
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    nextCycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
